// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer that shares one alu32 among NREQ requesters.
// Optional feature: define ALU_SHARE_SLTU_EN to make opcode 111 an unsigned set-less-than.
module alu32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        a_invert_i,
  input  logic        b_invert_i,
  input  logic        cin_i,
  input  logic [1:0]  operation_i,
  input  logic        less_i,
  output logic [31:0] result_o,
  output logic        cout_o,
  output logic        ovf_o
);
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [32:0] sum_s;

  always_comb begin
    a_s    = a_invert_i ? ~a_i : a_i;
    b_s    = b_invert_i ? ~b_i : b_i;
    sum_s  = {1'b0, a_s} + {1'b0, b_s} + {32'd0, cin_i};
    cout_o = sum_s[32];
    ovf_o  = (a_s[31] == b_s[31]) && (sum_s[31] != a_s[31]);
    case (operation_i)
      2'b00:   result_o = a_s & b_s;
      2'b01:   result_o = a_s | b_s;
      2'b10:   result_o = sum_s[31:0];
      2'b11:   result_o = {31'd0, less_i};
      default: result_o = 32'd0;
    endcase
  end
endmodule

module alu_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [3*NREQ-1:0]    req_op_i,
  input  logic [32*NREQ-1:0]   req_a_i,
  input  logic [32*NREQ-1:0]   req_b_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [31:0]          rsp_result_o,
  output logic                 rsp_cout_o,
  output logic                 rsp_ovf_o,
  output logic                 rsp_zero_o,
  output logic                 rsp_err_o
);
  typedef enum logic [1:0] {IDLE, EXEC, SLT2, RESP} state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SLT  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  state_t          state_q;
  logic [IDW-1:0]  rr_q;
  logic [IDW-1:0]  id_q;
  logic [2:0]      op_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [31:0]     result_q;
  logic            lt_q;
  logic            cout_q;
  logic            ovf_q;
  logic            zero_q;
  logic            err_q;
  logic            rsp_valid_q;

  logic [2*NREQ-1:0] valid2_s;
  logic [IDW:0]      pos_s;
  logic [IDW-1:0]    win_s;
  logic [IDW-1:0]    rr_d;
  logic              win_found_s;
  logic [NREQ-1:0]   grant_s;

  logic              is_arith_s;
  logic              is_two_pass_s;
  logic              is_unsigned_s;
  logic              is_illegal_s;

  logic [1:0]        alu_op_s;
  logic              a_inv_s;
  logic              b_inv_s;
  logic              cin_s;
  logic              less_s;
  logic [31:0]       alu_res_s;
  logic              alu_cout_s;
  logic              alu_ovf_s;

  // The doubled valid vector lets the search start at rr without a modulo index.
  always_comb begin
    valid2_s    = {req_valid_i, req_valid_i};
    pos_s       = '0;
    win_s       = '0;
    win_found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = {1'b0, rr_q} + (IDW+1)'(k);
      if (!win_found_s && valid2_s[pos_s]) begin
        win_found_s = 1'b1;
        win_s = (pos_s >= (IDW+1)'(NREQ)) ? IDW'(pos_s - (IDW+1)'(NREQ)) : IDW'(pos_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
    grant_s = '0;
    if (state_q == IDLE && win_found_s) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    rr_d = (int'(win_s) == NREQ - 1) ? '0 : win_s + IDW'(1);
  end

  always_comb begin
    is_arith_s    = 1'b0;
    is_two_pass_s = 1'b0;
    is_unsigned_s = 1'b0;
    is_illegal_s  = 1'b0;
    case (op_q)
      OP_AND, OP_OR, OP_NOR, OP_NAND: is_illegal_s = 1'b0;
      OP_ADD, OP_SUB:                 is_arith_s = 1'b1;
      OP_SLT:                         is_two_pass_s = 1'b1;
      OP_SLTU: begin
`ifdef ALU_SHARE_SLTU_EN
        is_two_pass_s = 1'b1;
        is_unsigned_s = 1'b1;
`else
        is_illegal_s = 1'b1;
`endif
      end
      default: is_illegal_s = 1'b1;
    endcase
  end

  always_comb begin
    alu_op_s = 2'b00;
    a_inv_s  = 1'b0;
    b_inv_s  = 1'b0;
    cin_s    = 1'b0;
    less_s   = 1'b0;
    if (state_q == SLT2) begin
      alu_op_s = 2'b11;
      b_inv_s  = 1'b1;
      cin_s    = 1'b1;
      less_s   = lt_q;
    end else begin
      case (op_q)
        OP_OR:          alu_op_s = 2'b01;
        OP_ADD:         alu_op_s = 2'b10;
        OP_SUB, OP_SLT: begin alu_op_s = 2'b10; b_inv_s = 1'b1; cin_s = 1'b1; end
        OP_NOR:         begin a_inv_s = 1'b1; b_inv_s = 1'b1; end
        OP_NAND:        begin alu_op_s = 2'b01; a_inv_s = 1'b1; b_inv_s = 1'b1; end
`ifdef ALU_SHARE_SLTU_EN
        OP_SLTU:        begin alu_op_s = 2'b10; b_inv_s = 1'b1; cin_s = 1'b1; end
`endif
        default:        alu_op_s = 2'b00;
      endcase
    end
  end

  alu32 u_alu (
    .a_i         (a_q),
    .b_i         (b_q),
    .a_invert_i  (a_inv_s),
    .b_invert_i  (b_inv_s),
    .cin_i       (cin_s),
    .operation_i (alu_op_s),
    .less_i      (less_s),
    .result_o    (alu_res_s),
    .cout_o      (alu_cout_s),
    .ovf_o       (alu_ovf_s)
  );

  // Sequencer: capture, one or two ALU passes, then hold the response until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      result_q    <= 32'd0;
      lt_q        <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          if (win_found_s) begin
            op_q    <= req_op_i[3*int'(win_s) +: 3];
            a_q     <= req_a_i[32*int'(win_s) +: 32];
            b_q     <= req_b_i[32*int'(win_s) +: 32];
            id_q    <= win_s;
            rr_q    <= rr_d;
            state_q <= EXEC;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          if (is_two_pass_s) begin
            lt_q    <= is_unsigned_s ? ~alu_cout_s : (alu_res_s[31] ^ alu_ovf_s);
            cout_q  <= alu_cout_s;
            ovf_q   <= alu_ovf_s;
            err_q   <= 1'b0;
            state_q <= SLT2;
          end else if (is_illegal_s) begin
            result_q    <= 32'd0;
            zero_q      <= 1'b1;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            result_q    <= alu_res_s;
            zero_q      <= (alu_res_s == 32'd0);
            cout_q      <= is_arith_s ? alu_cout_s : 1'b0;
            ovf_q       <= is_arith_s ? alu_ovf_s : 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        SLT2: begin
          result_q    <= alu_res_s;
          zero_q      <= (alu_res_s == 32'd0);
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = grant_s;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;
  assign rsp_cout_o   = cout_q;
  assign rsp_ovf_o    = ovf_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_err_o    = err_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: arbitration predicted from a round-robin pointer,
// results from plain arithmetic on the opcode meaning.
module tb_alu_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid_i;
  logic [NREQ-1:0]     req_ready_o;
  logic [3*NREQ-1:0]   req_op_i;
  logic [32*NREQ-1:0]  req_a_i;
  logic [32*NREQ-1:0]  req_b_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [IDW-1:0]      rsp_id_o;
  logic [31:0]         rsp_result_o;
  logic                rsp_cout_o;
  logic                rsp_ovf_o;
  logic                rsp_zero_o;
  logic                rsp_err_o;

  alu_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o),
    .rsp_cout_o(rsp_cout_o), .rsp_ovf_o(rsp_ovf_o),
    .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        err;
    int          hs;
    int          lat;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];
  int   grant_log[$];
  bit   busy = 1'b0;
  int   rr   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b, int id);
    exp_t        e;
    logic [32:0] s;
    logic [31:0] d;
    bit          sub_c;
    bit          sub_v;
    d     = a - b;
    sub_c = (a >= b);
    sub_v = (a[31] != b[31]) && (d[31] != a[31]);
    e.id = id; e.res = 32'd0; e.cout = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.hs = 0; e.lat = 2;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0]; e.cout = s[32];
        e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd3: begin e.res = d; e.cout = sub_c; e.ovf = sub_v; end
      3'd4: begin
        e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        e.cout = sub_c; e.ovf = sub_v; e.lat = 3;
      end
      3'd5: e.res = ~(a | b);
      3'd6: e.res = ~(a & b);
      default: begin
`ifdef ALU_SHARE_SLTU_EN
        e.res = (a < b) ? 32'd1 : 32'd0;
        e.cout = sub_c; e.ovf = sub_v; e.lat = 3;
`else
        e.err = 1'b1;
`endif
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h7FFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'hFFFFFFFF;
      4:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle of stimulus; predicts req_ready and enqueues the expected response.
  task automatic step(logic [NREQ-1:0] v, logic [3*NREQ-1:0] ops,
                      logic [32*NREQ-1:0] as, logic [32*NREQ-1:0] bs, logic rdy);
    int              win;
    logic [NREQ-1:0] exp_ready;
    exp_t            e;
    req_valid_i = v; req_op_i = ops; req_a_i = as; req_b_i = bs; rsp_ready_i = rdy;
    @(negedge clk);
    win = -1;
    exp_ready = '0;
    if (!busy) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && v[(rr + k) % NREQ]) win = (rr + k) % NREQ;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", 32'(req_ready_o), 32'(exp_ready));
    if (win >= 0) begin
      e = model(ops[3*win +: 3], as[32*win +: 32], bs[32*win +: 32], win);
      e.hs = cyc;
      sbq.push_back(e);
      grant_log.push_back(win);
      busy = 1'b1;
      rr = (win + 1) % NREQ;
    end else if (busy && rsp_valid_o && rdy) begin
      busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (busy || sbq.size() != 0); k++) step('0, '0, '0, '0, 1'b1);
    check("drain_done", 32'(busy), 32'd0);
    busy = 1'b0;
    sbq.delete();
  endtask

  task automatic issue(int i, logic [2:0] op, logic [31:0] a, logic [31:0] b, int hold);
    logic [NREQ-1:0]    v;
    logic [3*NREQ-1:0]  ops;
    logic [32*NREQ-1:0] as;
    logic [32*NREQ-1:0] bs;
    v = '0; ops = '0; as = '0; bs = '0;
    v[i] = 1'b1; ops[3*i +: 3] = op; as[32*i +: 32] = a; bs[32*i +: 32] = b;
    step(v, ops, as, bs, 1'b1);
    for (int k = 0; k < hold; k++) step('0, '0, '0, '0, 1'b0);
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid_i = '0; rsp_ready_i = 1'b0;
    sbq.delete(); busy = 1'b0; rr = 0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_result", rsp_result_o, 32'd0);
    check("rst_id", 32'(rsp_id_o), 32'd0);
    check("rst_flags", {28'd0, rsp_cout_o, rsp_ovf_o, rsp_zero_o, rsp_err_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compares every cycle rsp_valid is high, pops on acceptance.
  initial begin
    exp_t e;
    bit   in_rsp;
    in_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_rsp = 1'b0;
      end else if (rsp_valid_o) begin
        if (sbq.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
        end else begin
          e = sbq[0];
          if (!in_rsp) check("latency", 32'(cyc - e.hs), 32'(e.lat));
          in_rsp = 1'b1;
          check("rsp_id", 32'(rsp_id_o), 32'(e.id));
          check("rsp_result", rsp_result_o, e.res);
          check("rsp_cout", 32'(rsp_cout_o), 32'(e.cout));
          check("rsp_ovf", 32'(rsp_ovf_o), 32'(e.ovf));
          check("rsp_zero", 32'(rsp_zero_o), 32'(e.zero));
          check("rsp_err", 32'(rsp_err_o), 32'(e.err));
          if (rsp_ready_i) begin
            void'(sbq.pop_front());
            in_rsp = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0; rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    issue(2, 3'd2, 32'h7FFFFFFF, 32'h00000001, 0);
    issue(0, 3'd3, 32'd5, 32'd5, 0);
    issue(1, 3'd4, 32'hFFFFFFFF, 32'd1, 0);
    issue(3, 3'd7, 32'hFFFFFFFF, 32'd1, 0);
    issue(2, 3'd0, 32'hDEADBEEF, 32'h0F0F0F0F, 0);
    issue(0, 3'd1, 32'h12340000, 32'h00005678, 0);
    issue(1, 3'd5, 32'hF0F0F0F0, 32'h0F0F0F00, 0);

    // All four requesters contend with the same NAND; grants rotate from 0.
    do_reset();
    grant_log.delete();
    for (int n = 0; n < 30 && grant_log.size() < 5; n++)
      step({NREQ{1'b1}}, {NREQ{3'd6}}, {NREQ{32'hF0F0F0F0}}, {NREQ{32'hFF00FF00}}, 1'b1);
    drain();
    check("grant_count", 32'(grant_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check("grant_order", 32'(grant_log[k]), 32'(k % NREQ));

    // Response held off by rsp_ready low.
    issue(3, 3'd2, 32'h00001000, 32'hFFFFF000, 7);

    // Reset while the second SLT pass is in progress.
    issue(0, 3'd0, 32'd1, 32'd1, 0);
    step(4'b0001, {4{3'd4}}, {4{32'h80000000}}, {4{32'd3}}, 1'b1);
    step('0, '0, '0, '0, 1'b1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step('0, '0, '0, '0, 1'b1);
      check("no_rsp_after_rst", 32'(rsp_valid_o), 32'd0);
    end
    issue(1, 3'd3, 32'd10, 32'd20, 0);

    // Random contention with random back-pressure.
    for (int n = 0; n < 400; n++) begin
      logic [NREQ-1:0]    v;
      logic [3*NREQ-1:0]  ops;
      logic [32*NREQ-1:0] as;
      logic [32*NREQ-1:0] bs;
      v = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        ops[3*i +: 3]  = 3'($urandom_range(0, 7));
        as[32*i +: 32] = rnd32();
        bs[32*i +: 32] = rnd32();
      end
      step(v, ops, as, bs, ($urandom_range(0, 3) != 0));
    end
    drain();
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
